hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage MIPS core. Decides each cycle whether PC and
//  IF/ID advance, and whether IF/ID and ID/EX are flushed (bubble inserted). Covers load-use
//  interlock, EX-stage taken branch, ID-stage jump, and a multi-cycle mult/div busy window.
//  Sits beside the decoder. Drives PC enable, IF/ID write/flush and the ID/EX flush input.
// PARAMETERS
//  MD_LATENCY  32  cycles mult/div unit busy after issue (legal range 2..255)
//  CNT_W       16  width of stall performance counter
// PORTS
//  clk              in   1      clock, rising edge
//  reset            in   1      asynchronous, active-high
//  id_rs, id_rt     in   5      source regs of instruction in ID
//  id_uses_rs/rt    in   1      ID instruction actually reads rs / rt
//  id_jump          in   1      j/jal/jr decoded in ID
//  id_md_start      in   1      ID holds mult/div (starts MD unit when it leaves ID)
//  id_md_use        in   1      ID holds mfhi/mflo/mult/div (needs MD result or unit)
//  ex_rt            in   5      rt of instruction in EX
//  ex_mem_read      in   1      EX holds a load (ID/EX MemtoReg == 2'b01)
//  ex_branch_taken  in   1      branch in EX resolved taken
//  pc_write         out  1      PC enable
//  if_id_write      out  1      IF/ID enable
//  if_id_flush      out  1      clear IF/ID next edge
//  id_ex_flush      out  1      clear ID/EX next edge (bubble)
//  md_busy          out  1      MD unit busy (state BUSY)
//  stall_cnt        out  CNT_W  saturating count of cycles with pc_write==0
// BEHAVIOUR
//  - Flush/enable outputs combinational from state + inputs (same-cycle effect); state regs async reset.
//  - Reset (asserted): state IDLE, md counter 0, stall_cnt 0; outputs forced pc_write=1,
//    if_id_write=1, if_id_flush=0, id_ex_flush=0, md_busy=0. Reset mid-BUSY aborts window.
//  - load_use = ex_mem_read & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
//  - md_stall = (state==BUSY) & id_md_use.
//  - Priority, highest first:
//    1 ex_branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1 (stalls/jump ignored).
//    2 load_use | md_stall: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1. 1-cycle
//      load-use bubble; md_stall repeats until counter expires.
//    3 id_jump: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=0.
//    4 else: pc_write=1, if_id_write=1, flushes 0.
//  - FSM IDLE/BUSY. issue = id_md_start & !ex_branch_taken & !load_use & !md_stall.
//    IDLE --issue--> BUSY, counter <= MD_LATENCY-1. BUSY: counter decrements each cycle;
//    at counter==0 -> IDLE next edge (md_busy low that edge). Window = MD_LATENCY cycles after issue.
//    Branch taken while BUSY: window continues (MD op already issued).
//    id_md_start while BUSY is stalled via md_stall (id_md_use also high); issues on the cycle
//    BUSY->IDLE completes, i.e. first IDLE cycle.
//  - stall_cnt += 1 on each non-reset cycle with pc_write==0; saturates at 2^CNT_W-1, no wrap.
//  - ex_rt==0 load never stalls. Same register on rs and rt counts once (single stall).
// STRUCTURE
//  - Shared package hazard_pkg: state encodings ST_IDLE/ST_BUSY, MD_CNT_W=8, priority enum.
//  - One sub-module md_busy_timer (load, decrement, busy/expire) instantiated once; rest inline.
// TESTING
//  1 lw $8 in EX (ex_mem_read=1, ex_rt=8), ID add uses rs=8 -> cycle: pc_write=0, if_id_write=0,
//    id_ex_flush=1; next cycle (ex_mem_read=0) all normal; stall_cnt=1.
//  2 ex_branch_taken=1 with load_use=1 and id_jump=1 -> pc_write=1, if_id_flush=1, id_ex_flush=1.
//  3 id_jump=1 alone -> if_id_flush=1, id_ex_flush=0, pc_write=1.
//  4 MD_LATENCY=4: issue div at cycle 0; mflo in ID cycles 1..3 -> stalled 3 cycles, md_busy
//    high cycles 1..4, mflo proceeds cycle 4? no: counter 3,2,1,0 -> IDLE after cycle 4; mflo
//    stalled cycles 1..4, proceeds cycle 5; stall_cnt=4.
//  5 reset pulse mid-BUSY (counter=2) -> md_busy=0, stall_cnt=0, IDLE immediately (async).
//  6 Force 2^CNT_W+3 stall cycles -> stall_cnt holds 2^CNT_W-1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its mult/div timer.
package hazard_pkg;

  localparam int MD_CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  typedef enum logic [1:0] {
    PRI_BRANCH = 2'd0,
    PRI_STALL  = 2'd1,
    PRI_JUMP   = 2'd2,
    PRI_NONE   = 2'd3
  } pri_t;

endpackage

// File: rtl/md_busy_timer.sv
// Down-counter timing the mult/div busy window: loaded on issue, decremented while busy.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int LOAD_VAL = 31
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic expire
);

  logic [MD_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= MD_CNT_W'(LOAD_VAL);
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use interlock, branch/jump flushes and the
// mult/div busy window, with a saturating count of stalled cycles.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_md_start,
  input  logic             id_md_use,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  md_state_t state_q, state_d;
  pri_t      pri;
  logic      load_use, md_stall, issue, md_expire;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
  assign md_stall = (state_q == ST_BUSY) && id_md_use;
  assign issue    = id_md_start && !ex_branch_taken && !load_use && !md_stall;

  md_busy_timer #(
    .LOAD_VAL(MD_LATENCY - 1)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   ((state_q == ST_IDLE) && issue),
    .dec    (state_q == ST_BUSY),
    .expire (md_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue)     state_d = ST_BUSY;
      ST_BUSY: if (md_expire) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if (ex_branch_taken)            pri = PRI_BRANCH;
    else if (load_use || md_stall)  pri = PRI_STALL;
    else if (id_jump)               pri = PRI_JUMP;
    else                            pri = PRI_NONE;
  end

  // Reset forces a free-running, unflushed pipeline regardless of the hazard inputs.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    md_busy     = !reset && (state_q == ST_BUSY);
    if (!reset) begin
      case (pri)
        PRI_BRANCH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        PRI_STALL: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
        PRI_JUMP:  if_id_flush = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (!pc_write && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int MD_LAT = 4;
  localparam int CW     = 8;
  localparam int MAXC   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rs, id_uses_rt, id_jump, id_md_start, id_md_use;
  logic          ex_mem_read, ex_branch_taken;
  logic          pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy;
  logic [CW-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  int md_rem = 0;
  int scnt = 0;

  hazard_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .id_md_start(id_md_start), .id_md_use(id_md_use),
    .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
    id_md_start = 1'b0; id_md_use = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic lu_in(input logic [4:0] r);
    idle_in();
    id_rs = r; id_uses_rs = 1'b1; ex_rt = r; ex_mem_read = 1'b1;
  endtask

  // Check one cycle mid-period, then advance the model across the rising edge.
  task automatic step(input string tag);
    logic lu, ms, stall, issue;
    logic e_pc, e_ifw, e_iff, e_idf;
    @(negedge clk);
    lu = ex_mem_read && (ex_rt != 0) &&
         ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    ms = (md_rem > 0) && id_md_use;
    stall = lu || ms;
    if (ex_branch_taken)  {e_pc, e_ifw, e_iff, e_idf} = 4'b1111;
    else if (stall)       {e_pc, e_ifw, e_iff, e_idf} = 4'b0001;
    else if (id_jump)     {e_pc, e_ifw, e_iff, e_idf} = 4'b1110;
    else                  {e_pc, e_ifw, e_iff, e_idf} = 4'b1100;
    chk({tag, ".pc_write"},    32'(pc_write),    32'(e_pc));
    chk({tag, ".if_id_write"}, 32'(if_id_write), 32'(e_ifw));
    chk({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(e_iff));
    chk({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'(e_idf));
    chk({tag, ".md_busy"},     32'(md_busy),     32'(md_rem > 0));
    chk({tag, ".stall_cnt"},   32'(stall_cnt),   32'(scnt));
    issue = id_md_start && !ex_branch_taken && !stall;
    @(posedge clk);
    if (md_rem > 0)  md_rem = md_rem - 1;
    else if (issue)  md_rem = MD_LAT;
    if (!e_pc && scnt < MAXC) scnt = scnt + 1;
    #1;
  endtask

  task automatic release_reset();
    idle_in();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    #2;
    chk("rst.pc_write", 32'(pc_write), 32'd1);
    chk("rst.md_busy", 32'(md_busy), 32'd0);
    chk("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    lu_in(5'd8);
    ex_branch_taken = 1'b1;
    #1;
    chk("rst.forced_pc", 32'(pc_write), 32'd1);
    chk("rst.forced_flush", 32'({if_id_flush, id_ex_flush}), 32'd0);
    release_reset();

    // Load-use on rs, then clean cycle
    lu_in(5'd8);
    step("lu");
    idle_in();
    step("lu_after");
    chk("lu.count", 32'(stall_cnt), 32'd1);

    // Load to $0 never stalls; same register on rs and rt stalls once
    lu_in(5'd0);
    step("lu_r0");
    lu_in(5'd5);
    id_rt = 5'd5; id_uses_rt = 1'b1;
    step("lu_both");
    idle_in();
    step("lu_both_after");
    chk("lu_both.count", 32'(stall_cnt), 32'd2);

    // Branch dominates load-use and jump
    lu_in(5'd9);
    id_jump = 1'b1; ex_branch_taken = 1'b1;
    step("branch");
    idle_in();
    id_jump = 1'b1;
    step("jump");

    // div issue then mflo waits out the window
    idle_in();
    id_md_start = 1'b1; id_md_use = 1'b1;
    step("md_issue");
    id_md_start = 1'b0;
    for (int i = 0; i < MD_LAT; i++) begin
      chk("md.busy_window", 32'(md_busy), 32'd1);
      step("md_wait");
    end
    step("md_go");
    chk("md.count", 32'(stall_cnt), 32'd6);

    // Async reset mid-window
    idle_in();
    id_md_start = 1'b1; id_md_use = 1'b1;
    step("md_issue2");
    idle_in();
    step("md_run2");
    lu_in(5'd3);
    reset = 1'b1;
    #1;
    md_rem = 0;
    scnt = 0;
    chk("midrst.md_busy", 32'(md_busy), 32'd0);
    chk("midrst.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("midrst.pc_write", 32'(pc_write), 32'd1);
    release_reset();
    step("post_rst");

    // Saturation of the stall counter
    lu_in(5'd7);
    repeat (MAXC + 4) step("sat");
    chk("sat.hold", 32'(stall_cnt), 32'(MAXC));
    idle_in();
    step("sat_after");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_uses_rs      = ($urandom_range(0, 1) == 0);
      id_uses_rt      = ($urandom_range(0, 1) == 0);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      id_jump         = ($urandom_range(0, 7) == 0);
      id_md_start     = ($urandom_range(0, 9) == 0);
      id_md_use       = id_md_start || ($urandom_range(0, 4) == 0);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
